fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the byte-addressable instruction memory: 256 bytes, big-endian, combinational read of 4 bytes at a 32-bit address.
- Holds the program counter and drives inst_address.
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles sequential advance, branch/jump redirect, stall, halt and bubble insertion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, word placed in ifid_instr on bubble or flush
IMEM_BYTES, 256, instruction memory size; used only for the pc_oor flag

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
instruction  in  32  word from instruction memory for the current inst_address (same cycle)
inst_address  out  32  current PC, driven combinationally from the PC register
stall  in  1  hold PC and IF/ID contents
halt  in  1  enter HALTED at the next edge
branch_taken  in  1  redirect to branch_target
branch_target  in  32  branch destination
jump  in  1  redirect to jump_target
jump_target  in  32  jump destination
ifid_instr  out  32  latched instruction
ifid_pc_plus4  out  32  PC+4 of the latched instruction
ifid_valid  out  1  ifid_instr is a real instruction, not a bubble
halted  out  1  high in HALTED state
misalign_err  out  1  one-cycle pulse when a redirect target has [1:0] != 0
pc_oor  out  1  combinational; PC >= IMEM_BYTES (memory aliases)

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - PC = RESET_PC, state = BOOT.
  - ifid_instr = NOP_WORD, ifid_pc_plus4 = 0, ifid_valid = 0.
  - halted = 0, misalign_err = 0.
- States:
  - BOOT: lasts exactly one cycle after reset deassertion. The IF/ID register is not loaded. PC is not advanced. Next state is RUN.
  - RUN: normal fetch.
  - HALTED: PC frozen; IF/ID loaded with bubble at each edge; halted = 1. Exited only by reset.
- Latency: ifid_instr at cycle n+1 = instruction presented while inst_address = PC at cycle n. One cycle, no extra wait states.
- RUN per-edge priority, highest first:
  1. halt = 1: go to HALTED. PC unchanged. IF/ID takes a bubble.
  2. jump = 1: PC = {jump_target[31:2], 2'b00}. IF/ID takes a bubble (flush of the wrong-path fetch).
  3. branch_taken = 1: PC = {branch_target[31:2], 2'b00}. IF/ID takes a bubble.
  4. stall = 1: PC and all IF/ID outputs hold their values.
  5. Otherwise: PC = PC + 4. IF/ID takes instruction, PC+4, valid = 1.
- jump and branch_taken both high: jump wins, branch is ignored.
- Redirect with stall high: the redirect wins and the flush bubble is inserted. A stall must never block a redirect.
- Inputs during BOOT: halt, jump, branch and stall are ignored.
- misalign_err: registered; high for the one cycle after an edge where the redirect taken had target[1:0] != 0. The PC is still loaded with the forced-aligned value.
- Arithmetic: PC is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No stall or error is raised on wrap. pc_oor is informational only.
- Bubble definition: ifid_instr = NOP_WORD, ifid_valid = 0, ifid_pc_plus4 = 0.
- Registers: all are reset asynchronously and updated on the rising clock edge only. There are no latches.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch state enumeration (BOOT, RUN, HALTED);
  - the NOP_WORD constant;
  - the INSTR_W = 32 constant;
  - the PC_STEP = 4 constant.
- One sub-module is natural: ifid_reg, the IF/ID pipeline register.
  - Inputs: load, bubble, instr, pc_plus4.
  - Outputs: the three ifid_* signals.
  - It has its own async reset.
  - It is reused for the later ID/EX register style.
- The PC register, next-PC mux and FSM stay in fetch_unit.

Test Plan:
- Reset then release, memory words at bytes 0/4/8 = 32'h11111111/22222222/33333333:
  - cycle 1: ifid_valid = 0, inst_address = 0;
  - the next three edges give ifid_instr 11111111, 22222222, 33333333 with ifid_pc_plus4 = 4, 8, 12.
- stall high for 3 cycles at PC = 8 -> inst_address stays 8; ifid_instr stays 22222222 with valid = 1; the sequence resumes at 33333333 after release.
- branch_taken = 1 with branch_target = 32'h40 at PC = 12 -> the next edge gives inst_address = 0x40 and ifid_valid = 0; the following edge gives ifid_pc_plus4 = 0x44.
- jump = 1 (target 0x80), branch_taken = 1 (target 0x40) and stall = 1, all on the same edge -> PC = 0x80, bubble inserted, misalign_err = 0.
- jump_target = 32'h0000_0086 -> PC = 0x84 and misalign_err pulses for exactly 1 cycle; PC = 32'hFFFF_FFFC with no redirect -> the next PC is 0 and pc_oor toggles as expected.
- halt pulse at PC = 0x10 -> halted = 1, PC frozen at 0x10, ifid_valid = 0 permanently. Asserting reset mid-cycle returns all outputs to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline front end.
//
// Contents:
//   INSTR_W        instruction word width in bits
//   PC_STEP        sequential program-counter increment (one word)
//   NOP_WORD       instruction word used for pipeline bubbles
//   fetch_state_t  fetch-stage state machine encoding (BOOT, RUN, HALTED)

package cpu_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: carries one fetched instruction and its PC+4
// into the decode stage, with bubble insertion and hold.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset (register becomes a bubble)
//   load           capture instr/pc_plus4 as a valid instruction
//   bubble         replace the contents with a bubble (wins over load)
//   instr          instruction word to capture
//   pc_plus4       PC+4 of that instruction
//   ifid_instr     latched instruction (BUBBLE_WORD when invalid)
//   ifid_pc_plus4  latched PC+4 (zero when invalid)
//   ifid_valid     latched instruction is real, not a bubble
//
// With neither load nor bubble asserted the register holds, which is how
// a stall is realised.

module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] BUBBLE_WORD = NOP_WORD
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] instr,
    input  logic [31:0]        pc_plus4,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [31:0]        ifid_pc_plus4,
    output logic               ifid_valid
);

    // Bubble has priority so a flush can never be overridden by a load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifid_instr    <= BUBBLE_WORD;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
        end else if (bubble) begin
            ifid_instr    <= BUBBLE_WORD;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
        end else if (load) begin
            ifid_instr    <= instr;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the program counter, drives the
// instruction-memory address, and fills the IF/ID register for decode.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   instruction    word returned by instruction memory for inst_address
//   inst_address   current PC (combinational from the PC register)
//   stall          hold PC and IF/ID
//   halt           enter HALTED at the next edge
//   branch_taken   redirect to branch_target
//   branch_target  branch destination
//   jump           redirect to jump_target (wins over branch_taken)
//   jump_target    jump destination
//   ifid_instr     latched instruction
//   ifid_pc_plus4  PC+4 of the latched instruction
//   ifid_valid     latched instruction is real, not a bubble
//   halted         high in HALTED state
//   misalign_err   one-cycle pulse after a redirect to a non-word-aligned target
//   pc_oor         PC lies beyond the instruction memory (memory aliases)

module fetch_unit
    import cpu_pkg::INSTR_W;
    import cpu_pkg::PC_STEP;
    import cpu_pkg::fetch_state_t;
    import cpu_pkg::BOOT;
    import cpu_pkg::RUN;
    import cpu_pkg::HALTED;
#(
    parameter logic [31:0]        RESET_PC   = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_WORD   = cpu_pkg::NOP_WORD,
    parameter int                 IMEM_BYTES = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    output logic [31:0]        inst_address,
    input  logic               stall,
    input  logic               halt,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [31:0]        ifid_pc_plus4,
    output logic               ifid_valid,
    output logic               halted,
    output logic               misalign_err,
    output logic               pc_oor
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        ifid_load;
    logic        ifid_bubble;
    logic        misalign_next;

    // PC+4 wraps naturally modulo 2^32; no error is raised on wrap.
    assign pc_plus4     = pc + PC_STEP;
    assign inst_address = pc;
    assign pc_oor       = (pc >= 32'(IMEM_BYTES));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. BOOT is a single settling cycle; HALTED only
    // leaves through reset.
    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = halt ? HALTED : RUN;
            HALTED:  state_next = HALTED;
            default: state_next = BOOT;
        endcase
    end

    // Output and datapath control. In RUN the priority is
    // halt > jump > branch > stall > sequential advance, so a stall never
    // blocks a redirect. Redirect targets are forced word-aligned, and a
    // misaligned request is reported one cycle later via misalign_err.
    always_comb begin
        pc_next       = pc;
        ifid_load     = 1'b0;
        ifid_bubble   = 1'b0;
        misalign_next = 1'b0;
        halted        = 1'b0;
        unique case (state)
            BOOT: begin
            end
            RUN: begin
                if (halt) begin
                    ifid_bubble = 1'b1;
                end else if (jump) begin
                    pc_next       = {jump_target[31:2], 2'b00};
                    ifid_bubble   = 1'b1;
                    misalign_next = |jump_target[1:0];
                end else if (branch_taken) begin
                    pc_next       = {branch_target[31:2], 2'b00};
                    ifid_bubble   = 1'b1;
                    misalign_next = |branch_target[1:0];
                end else if (!stall) begin
                    pc_next   = pc_plus4;
                    ifid_load = 1'b1;
                end
            end
            HALTED: begin
                ifid_bubble = 1'b1;
                halted      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // PC and misalignment flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_next;
            misalign_err <= misalign_next;
        end
    end

    ifid_reg #(
        .BUBBLE_WORD (NOP_WORD)
    ) u_ifid_reg (
        .clock         (clock),
        .reset         (reset),
        .load          (ifid_load),
        .bubble        (ifid_bubble),
        .instr         (instruction),
        .pc_plus4      (pc_plus4),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
    );

endmodule
